decrypt_ctrl: RTL

DECRYPT_CTRL -- requirements
Module: decrypt_ctrl

---
 rtl/decrypt_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/decrypt_ctrl.sv
// Sequencing controller for an iterated Feistel decryption datapath: loads a ciphertext
// block, applies the round keys in reverse order and hands the plaintext out.
module decrypt_ctrl #(
    parameter  int unsigned DATAW  = 16,
    parameter  int unsigned ROUNDS = 32,
    localparam int unsigned RKAW   = $clog2(ROUNDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_hi,
    input  logic [DATAW-1:0] in_lo,
    output logic [RKAW-1:0]  rk_addr,
    input  logic [DATAW-1:0] rk_data,
    output logic             dp_dctr,
    output logic [DATAW-1:0] dp_data,
    output logic [DATAW-1:0] dp_C,
    input  logic [DATAW-1:0] dp_data1,
    input  logic [DATAW-1:0] dp_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_hi,
    output logic [DATAW-1:0] out_lo,
    output logic             busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadR,
        StLoadL,
        StRound,
        StCapture,
        StDone
    } state_e;

    localparam logic [RKAW-1:0] LastRnd = RKAW'(ROUNDS - 1);

    state_e            state_q;
    logic [RKAW-1:0]   rnd_q;
    logic [DATAW-1:0]  hi_q;
    logic [DATAW-1:0]  lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rnd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            out_hi  <= '0;
            out_lo  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        hi_q    <= in_hi;
                        lo_q    <= in_lo;
                        state_q <= StLoadR;
                    end
                end
                StLoadR: state_q <= StLoadL;
                StLoadL: begin
                    rnd_q   <= '0;
                    state_q <= StRound;
                end
                StRound: begin
                    rnd_q <= rnd_q + 1'b1;
                    if (rnd_q == LastRnd) state_q <= StCapture;
                end
                // Datapath registers still hold the final round result at this edge.
                StCapture: begin
                    out_hi  <= dp_data1;
                    out_lo  <= dp_out;
                    state_q <= StDone;
                end
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Idle datapath cycles load zero so stale block data never lingers.
    always_comb begin
        dp_dctr = 1'b1;
        dp_data = '0;
        dp_C    = '0;
        rk_addr = '0;
        unique case (state_q)
            StLoadR: dp_data = lo_q;
            StLoadL: dp_data = hi_q;
            StRound: begin
                dp_dctr = 1'b0;
                rk_addr = LastRnd - rnd_q;
                dp_C    = rk_data;
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);

endmodule
